bnn_exec_unit: RTL and testbench
================================

Name: bnn_exec_unit

Overview:
- Multi-cycle Execute-stage unit, directly downstream of the decoder.
- Consumes the decoded custom BNN controls: BNNCMS (set matrix size), BCNV (binarized convolution) and BNN (convolution plus threshold).
- Holds the architectural matrix-size register and computes XNOR-popcount over the first MS bits of two 32-bit operands, LANE bits per cycle.
- Optionally thresholds the popcount to a single bit; asserts busy so the hazard unit can stall the front end.

Parameters:
- XLEN, 32, operand width; MS values are capped at XLEN.
- LANE, 8, bits processed per ACCUM cycle; must divide XLEN.
- MS_RESET, 9, matrix-size register value after reset (3x3 kernel).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ms_we_i  in  1  write matrix-size register (BNNCMS in E).
- start_i  in  1  begin BCNV/BNN operation (E stage).
- en_threshold_i  in  1  threshold the result (BNN op).
- flush_i  in  1  kill any in-flight operation.
- op_a_i  in  XLEN  activations; for BNNCMS, the new size in [5:0].
- op_b_i  in  XLEN  weights.
- thr_i  in  6  threshold value.
- busy_o  out  1  operation in flight; stall request.
- result_valid_o  out  1  one-cycle pulse when result_o updates.
- result_o  out  XLEN  popcount zero-extended, or 0/1 threshold result.
- ms_o  out  6  current matrix-size register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ms_q=MS_RESET, busy_o=0, result_valid_o=0, result_o=0.
  - Reset mid-operation aborts immediately and produces no result.
- Matrix-size write, ms_we_i=1 at a clock edge: ms_q <= sanitize(op_a_i[5:0]).
  - sanitize: 0 maps to 1; values above XLEN map to XLEN; otherwise unchanged.
  - Writes are accepted in any state. An in-flight op uses its latched copy.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start_i=1 latches op_a_i, op_b_i, en_threshold_i, thr_i and the effective MS.
  - Effective MS is the sanitized new value if ms_we_i is also 1 that cycle; otherwise ms_q.
  - Clears acc (6 bits) and idx=0, then moves to ACCUM.
- ACCUM, each cycle:
  - Lane bits are idx*LANE .. idx*LANE+LANE-1.
  - mask bit j = 1 iff (idx*LANE+j) < MS.
  - acc += popcount(~(a ^ b) over the lane, AND mask).
  - idx += 1.
  - Leave to DONE when (idx+1)*LANE >= MS; bits at or above MS never contribute.
- DONE (one cycle):
  - result_o <= en_thr ? {31'b0, (acc >= thr)} : zero-extended acc.
  - result_valid_o=1 this cycle only; next state IDLE.
  - result_o holds its value until the next DONE.
- busy_o = (state != IDLE), registered with state.
  - Deasserted in the cycle after DONE; equivalently low whenever state is IDLE.
- Latency: start accepted at edge 0; ceil(MS/LANE) ACCUM cycles; result_valid_o high in cycle ceil(MS/LANE)+1.
  - MS=9, LANE=8: valid in cycle 3.
  - MS=32: valid in cycle 5.
- start_i while busy: ignored, with no queueing. The hazard unit must hold the instruction until busy_o=0.
- flush_i:
  - Takes priority over start_i and the FSM; next state IDLE; no result_valid_o pulse; result_o unchanged.
  - flush_i and start_i in the same cycle: start is dropped.
  - flush_i does not affect the ms_q write.
- Width rules:
  - acc max is 32 and fits in 6 bits; no overflow is possible.
  - Threshold comparison is unsigned, 6-bit.

Test Plan:
- Reset: after reset release, ms_o=9, busy_o=0, result_o=0. Assert rst_n=0 mid-ACCUM, then release: busy_o=0 and no valid pulse.
- Popcount, MS=9: op_a=0x000001FF, op_b=0x000000FF, en_thr=0 → busy high cycles 1–3, result_valid_o in cycle 3, result_o=8. Then op_a=0xFFFFFE00, op_b=0 → result_o=9 (masked upper bits ignored).
- Threshold: same operands as the 8-popcount case with en_thr=1. thr=5 → result_o=1; thr=9 → result_o=0.
- Full width: BNNCMS with op_a=40 → ms_o=32. Then op_a=op_b=0xDEADBEEF → valid in cycle 5, result_o=32. BNNCMS with 0 → ms_o=1.
- Busy/flush:
  - Second start_i during ACCUM is ignored: exactly one valid pulse with the first op's result.
  - flush_i in cycle 2 of an MS=32 op: busy_o=0 next cycle, no valid pulse, result_o keeps its prior value.
- Same-cycle ms_we_i=1 (op_a=16) with start_i=1: op uses MS=16 and valid arrives in cycle 3. A later ms write during busy does not change the in-flight result.

Source files
------------

// File: rtl/bnn_exec_unit.sv
// BNN execute-stage unit. It holds the matrix-size register and computes an XNOR-popcount
// over the first MS operand bits, LANE bits per cycle, with an optional threshold.
module bnn_exec_unit #(
    parameter int XLEN     = 32,
    parameter int LANE     = 8,
    parameter int MS_RESET = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ms_we_i,
    input  logic            start_i,
    input  logic            en_threshold_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [5:0]      thr_i,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [5:0]      ms_o
);
    localparam int NUM_LANES = XLEN / LANE;
    localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       ms_q, ms_new, ms_eff;
    logic [5:0]       ms_op_q, thr_q;
    logic             en_thr_q;
    logic [XLEN-1:0]  match_q, ms_mask;
    logic [5:0]       acc_q, acc_next, lane_cnt;
    logic [IDX_W-1:0] idx_q;
    logic [LANE-1:0]  lane_vec;
    logic             last_lane, accept;
    logic [XLEN-1:0]  result_q;

    function automatic logic [5:0] sanitize(input logic [5:0] v);
        if (v == 6'd0) return 6'd1;
        if (int'(v) > XLEN) return 6'(XLEN);
        return v;
    endfunction

    assign ms_new = sanitize(op_a_i[5:0]);
    assign ms_eff = ms_we_i ? ms_new : ms_q;
    assign accept = (state_q == IDLE) && start_i && !flush_i;

    // Bits at or above MS are masked off once, when the operands are latched.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path infers a latch.
        ms_mask = '0;
        for (int i = 0; i < XLEN; i++) begin
            ms_mask[i] = (i < int'(ms_eff));
        end
    end

    always_comb begin
        lane_vec = LANE'(match_q >> (int'(idx_q) * LANE));
        lane_cnt = '0;
        for (int j = 0; j < LANE; j++) begin
            lane_cnt = lane_cnt + {5'd0, lane_vec[j]};
        end
        acc_next  = acc_q + lane_cnt;
        last_lane = ((int'(idx_q) + 1) * LANE) >= int'(ms_op_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = ACCUM;
            ACCUM:   if (last_lane) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_q     <= 6'(MS_RESET);
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            if (ms_we_i) ms_q <= ms_new;
            if (accept) begin
                acc_q <= '0;
                idx_q <= '0;
            end else if (state_q == ACCUM && !flush_i) begin
                acc_q <= acc_next;
                idx_q <= idx_q + IDX_W'(1);
                // Loaded on the last ACCUM edge so the data is stable during the DONE valid pulse.
                if (last_lane) begin
                    result_q <= en_thr_q ? XLEN'(acc_next >= thr_q) : XLEN'(acc_next);
                end
            end
        end
    end

    // NOTE: the operand latches have no reset because they are only read after a start loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            match_q  <= ~(op_a_i ^ op_b_i) & ms_mask;
            ms_op_q  <= ms_eff;
            en_thr_q <= en_threshold_i;
            thr_q    <= thr_i;
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign result_valid_o = (state_q == DONE);
    assign result_o       = result_q;
    assign ms_o           = ms_q;
endmodule

// File: tb/tb_bnn_exec_unit.sv
// Directed-plus-random bench for bnn_exec_unit. Expected values come from a
// bit-by-bit XNOR-count reference model.
module tb_bnn_exec_unit;
    localparam int XLEN = 32;
    localparam int LANE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ms_we_i = 1'b0, start_i = 1'b0, en_threshold_i = 1'b0, flush_i = 1'b0;
    logic [31:0] op_a_i = '0, op_b_i = '0;
    logic [5:0]  thr_i = '0;
    logic        busy_o, result_valid_o;
    logic [31:0] result_o;
    logic [5:0]  ms_o;

    int          checks = 0;
    int          failures = 0;
    int          valid_cnt = 0;
    int          model_ms = 9;
    logic [31:0] last_exp = '0;

    bnn_exec_unit #(.XLEN(XLEN), .LANE(LANE), .MS_RESET(9)) dut (
        .clk(clk), .rst_n(rst_n), .ms_we_i(ms_we_i), .start_i(start_i),
        .en_threshold_i(en_threshold_i), .flush_i(flush_i), .op_a_i(op_a_i),
        .op_b_i(op_b_i), .thr_i(thr_i), .busy_o(busy_o), .result_valid_o(result_valid_o),
        .result_o(result_o), .ms_o(ms_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (result_valid_o === 1'b1) valid_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sanitize_ref(input int v);
        if (v == 0) return 1;
        if (v > XLEN) return XLEN;
        return v;
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input int ms, input logic en, input logic [5:0] thr);
        int cnt = 0;
        for (int i = 0; i < ms; i++) if (a[i] == b[i]) cnt++;
        if (en) return (cnt >= int'(thr)) ? 32'd1 : 32'd0;
        return 32'(cnt);
    endfunction

    task automatic write_ms(input int v);
        op_a_i = 32'(v); ms_we_i = 1'b1;
        tick();
        ms_we_i = 1'b0;
        model_ms = sanitize_ref(v & 63);
        check("ms_write", 32'(ms_o), 32'(model_ms));
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic en, input logic [5:0] thr, input logic we);
        int ms, lat, cyc, v0;
        logic [31:0] exp_res;
        bit seen, busy_ok;
        ms = we ? sanitize_ref(int'(a[5:0])) : model_ms;
        model_ms = ms;
        exp_res = ref_result(a, b, ms, en, thr);
        lat = (ms + LANE - 1) / LANE + 1;
        v0 = valid_cnt;
        op_a_i = a; op_b_i = b; en_threshold_i = en; thr_i = thr; ms_we_i = we; start_i = 1'b1;
        tick();
        start_i = 1'b0; ms_we_i = 1'b0;
        cyc = 1; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && cyc <= 40) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (result_valid_o === 1'b1) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_result"}, result_o, exp_res);
        tick();
        check({tag, "_after"}, {30'd0, busy_o, result_valid_o}, 32'd0);
        check({tag, "_pulses"}, 32'(valid_cnt - v0), 32'd1);
        last_exp = exp_res;
    endtask

    initial begin
        logic [31:0] a1, b1, a2, b2, exp1;
        int v0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_ms", 32'(ms_o), 32'd9);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_valid", 32'(result_valid_o), 32'd0);

        run_op("pop8", 32'h0000_01FF, 32'h0000_00FF, 1'b0, 6'd0, 1'b0);
        check("pop8_value", result_o, 32'd8);
        run_op("pop9_masked", 32'hFFFF_FE00, 32'h0, 1'b0, 6'd0, 1'b0);
        check("pop9_value", result_o, 32'd9);
        run_op("thr5", 32'h0000_01FF, 32'h0000_00FF, 1'b1, 6'd5, 1'b0);
        check("thr5_value", result_o, 32'd1);
        run_op("thr9", 32'h0000_01FF, 32'h0000_00FF, 1'b1, 6'd9, 1'b0);
        check("thr9_value", result_o, 32'd0);

        // Reset in the middle of an accumulation.
        write_ms(32);
        op_a_i = $urandom; op_b_i = $urandom; en_threshold_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        v0 = valid_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_result", result_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_ms = 9; last_exp = '0;
        repeat (6) tick();
        check("midrst_nopulse", 32'(valid_cnt - v0), 32'd0);
        check("midrst_ms", 32'(ms_o), 32'd9);
        check("midrst_idle", 32'(busy_o), 32'd0);

        write_ms(40);
        run_op("full", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 6'd0, 1'b0);
        check("full_value", result_o, 32'd32);
        write_ms(0);
        run_op("ms1", $urandom, $urandom, 1'b0, 6'd0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) write_ms(int'($urandom_range(0, 63)));
            run_op("rand", $urandom, $urandom, 1'(($urandom) & 1), 6'($urandom_range(0, 40)),
                   1'(i % 4 == 1));
        end

        // A second start while busy is dropped.
        write_ms(32);
        a1 = $urandom; b1 = $urandom; a2 = ~a1; b2 = a1;
        exp1 = ref_result(a1, b1, 32, 1'b0, 6'd0);
        v0 = valid_cnt;
        op_a_i = a1; op_b_i = b1; en_threshold_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        op_a_i = a2; op_b_i = b2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (8) tick();
        check("busy_start_pulses", 32'(valid_cnt - v0), 32'd1);
        check("busy_start_result", result_o, exp1);
        check("busy_start_idle", 32'(busy_o), 32'd0);
        last_exp = exp1;

        // Flush in cycle 2 of a full-width op.
        v0 = valid_cnt;
        op_a_i = $urandom; op_b_i = $urandom; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        repeat (6) tick();
        check("flush_nopulse", 32'(valid_cnt - v0), 32'd0);
        check("flush_result_hold", result_o, last_exp);

        // Same-cycle size write and start, then a size write during busy.
        a1 = 32'h0000_0010 | ($urandom & 32'hFFFF_FFC0);
        run_op("same_cycle_ms16", a1, $urandom, 1'b0, 6'd0, 1'b1);
        a2 = $urandom; b2 = $urandom;
        exp1 = ref_result(a2, b2, 16, 1'b0, 6'd0);
        v0 = valid_cnt;
        op_a_i = a2; op_b_i = b2; en_threshold_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0; op_a_i = 32'd4; ms_we_i = 1'b1;
        tick();
        ms_we_i = 1'b0;
        model_ms = 4;
        repeat (4) tick();
        check("late_ms_pulses", 32'(valid_cnt - v0), 32'd1);
        check("late_ms_result", result_o, exp1);
        check("late_ms_reg", 32'(ms_o), 32'd4);
        last_exp = exp1;

        // Flush and start together: start dropped, size write still lands.
        op_a_i = 32'd20; op_b_i = $urandom; start_i = 1'b1; flush_i = 1'b1; ms_we_i = 1'b1;
        tick();
        start_i = 1'b0; flush_i = 1'b0; ms_we_i = 1'b0;
        model_ms = 20;
        check("flush_start_busy", 32'(busy_o), 32'd0);
        check("flush_start_ms", 32'(ms_o), 32'd20);
        repeat (4) tick();
        check("flush_start_result", result_o, last_exp);
        run_op("ms20", $urandom, $urandom, 1'b1, 6'd10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
